// File: rtl/fetch_stall_ctrl.sv
// IF-stage sequencer: PC/IF-ID enables, branch flush, and I-cache block refill over a req/ack port.
// Optional miss counter output enabled by defining FETCH_MISS_COUNT_EN.
module fetch_stall_ctrl #(
  parameter int SIZE        = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hit,
  input  logic [SIZE-1:0]                fetchPC,
  input  logic                           hazardStall,
  input  logic                           branchTaken,
  output logic                           memReq,
  output logic [SIZE-1:0]                memAddr,
  input  logic                           memAck,
  output logic                           refillWe,
  output logic [$clog2(BLOCK_WORDS)-1:0] refillIdx,
  output logic                           pcWrite,
  output logic                           ifidWrite,
  output logic                           ifidFlush,
`ifdef FETCH_MISS_COUNT_EN
  output logic [31:0]                    missCount,
`endif
  output logic                           busy
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [SIZE-1:0]  BLK_MASK  = SIZE'(BLOCK_WORDS * 4 - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESUME = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SIZE-1:0]   base_q, base_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic              miss_start;

  // Handshake: memReq/memAddr are held from registers until the cycle memAck=1,
  // which transfers exactly one word and advances to the next beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    beat_d     = beat_q;
    pcWrite    = 1'b0;
    ifidWrite  = 1'b0;
    ifidFlush  = 1'b0;
    refillWe   = 1'b0;
    miss_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (branchTaken) begin
          pcWrite   = 1'b1;
          ifidFlush = 1'b1;
        end else if (!hit) begin
          miss_start = 1'b1;
          state_d    = REFILL;
          base_d     = fetchPC & ~BLK_MASK;
          beat_d     = '0;
        end else if (!hazardStall) begin
          pcWrite   = 1'b1;
          ifidWrite = 1'b1;
        end
      end
      REFILL: begin
        // A redirect during refill only flushes; the block still completes.
        if (branchTaken) begin
          pcWrite   = 1'b1;
          ifidFlush = 1'b1;
        end
        if (memAck) begin
          refillWe = 1'b1;
          beat_d   = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = RESUME;
        end
      end
      RESUME: begin
        if (branchTaken) begin
          pcWrite   = 1'b1;
          ifidFlush = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      ifidFlush  = 1'b0;
      refillWe   = 1'b0;
      miss_start = 1'b0;
    end
  end

  assign memReq    = rst ? 1'b0 : (state_q == REFILL);
  assign memAddr   = rst ? '0 : base_q + {{(SIZE-IDX_W-2){1'b0}}, beat_q, 2'b00};
  assign refillIdx = rst ? '0 : beat_q;
  assign busy      = rst ? 1'b0 : (state_q != IDLE);

`ifdef FETCH_MISS_COUNT_EN
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    miss_count_d = miss_count_q;
    if (miss_start && miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) miss_count_q <= '0;
    else     miss_count_q <= miss_count_d;
  end

  assign missCount = rst ? 32'd0 : miss_count_q;
`else
  logic unused_miss_start;
  assign unused_miss_start = miss_start;
`endif

endmodule

// File: doc/fetch_stall_ctrl.md
Name: fetch_stall_ctrl

Overview:
- Controller that sequences the IF stage: the PC write enable and the IF/ID pipeline register enable/flush.
- Merges I-cache hit/miss, the load-use stall from ID and the branch flush from EX.
- On an I-cache miss, runs a multi-beat block refill from instruction memory with a req/ack handshake, then resumes fetch.
- Sits between the PC register, the I-cache, the IF/ID register and the memory interface.

Parameters:
- SIZE, 32, address/data width in bits.
- BLOCK_WORDS, 4, words per cache block; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- hit  in  1  I-cache hit for fetchPC this cycle.
- fetchPC  in  SIZE  address currently being fetched.
- hazardStall  in  1  load-use stall request from ID.
- branchTaken  in  1  redirect/flush request from EX.
- memReq  out  1  refill word request to instruction memory.
- memAddr  out  SIZE  byte address of the requested refill word.
- memAck  in  1  memory returns one word this cycle.
- refillWe  out  1  I-cache data write enable.
- refillIdx  out  log2(BLOCK_WORDS)  word index within block for refillWe.
- pcWrite  out  1  PC register load enable.
- ifidWrite  out  1  IF/ID register load enable (drives its hit input).
- ifidFlush  out  1  IF/ID loads a NOP.
- busy  out  1  refill in progress (state is not IDLE).

Behaviour:
- States: IDLE, REFILL, RESUME. Registers: state, base (SIZE), beat (log2(BLOCK_WORDS)).
- Reset, sampled at a clock edge while rst=1:
  - state=IDLE, base=0, beat=0.
  - While rst=1, all outputs are forced to 0.
- IDLE, priority branchTaken > miss > hazardStall:
  - branchTaken=1: pcWrite=1, ifidFlush=1, ifidWrite=0. No refill is started, even if hit=0.
  - hit=0: pcWrite=0, ifidWrite=0. Next state is REFILL. base = fetchPC with the low log2(BLOCK_WORDS)+2 bits cleared; beat=0.
  - hit=1 with hazardStall=1: pcWrite=0, ifidWrite=0.
  - hit=1 with hazardStall=0: pcWrite=1, ifidWrite=1.
- REFILL:
  - memReq=1; memAddr = base + 4*beat. Both are held stable until memAck.
  - memAck=1: refillWe=1, refillIdx=beat, beat increments.
  - memAck=1 with beat=BLOCK_WORDS-1: next state is RESUME and beat wraps to 0.
  - pcWrite=0, ifidWrite=0 unless branchTaken.
  - branchTaken=1: pcWrite=1, ifidFlush=1. The refill is not aborted and always completes to the latched base.
- RESUME:
  - Lasts one cycle so the cache re-reads; memReq=0, pcWrite=0, ifidWrite=0 (branchTaken still gives pcWrite=1, ifidFlush=1).
  - Next state is IDLE; hit is re-evaluated there.
- refillWe is asserted only in REFILL with memAck=1. memAck outside REFILL is ignored.
- Output timing:
  - memReq, memAddr, refillIdx and busy are derived only from registered state.
  - pcWrite, ifidWrite, ifidFlush and refillWe are combinational from state and inputs.
- Latency: a miss detected in cycle N gives memReq=1 in cycle N+1. Minimum miss penalty is BLOCK_WORDS+2 cycles.
- rst asserted mid-REFILL: next cycle is IDLE with beat=0 and no further refillWe. The partially written block is not invalidated by this block.

Optional Feature:
- Macro: FETCH_MISS_COUNT_EN.
- Defined:
  - Adds output port missCount (32 bits), reset to 0.
  - Increments on each IDLE->REFILL transition; saturates at 0xFFFF_FFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles with hit=0, memAck=1 -> all outputs 0; after release, state IDLE and busy=0.
- hit=1, hazardStall=0, branchTaken=0 for 5 cycles -> pcWrite=1 and ifidWrite=1 every cycle; memReq=0.
- BLOCK_WORDS=4, fetchPC=0x0000_0044, hit=0, memAck=1 every cycle:
  - memAddr sequence 0x40, 0x44, 0x48, 0x4C; refillIdx 0..3 with refillWe=1.
  - One RESUME cycle follows; busy=1 for 5 cycles; pcWrite=0 throughout.
- Same miss with memAck high only every 4th cycle -> memReq held at 1 and memAddr stable between acks; exactly 4 refillWe pulses.
- hit=1, hazardStall=1 -> pcWrite=0, ifidWrite=0. Adding branchTaken=1 -> pcWrite=1, ifidFlush=1, ifidWrite=0. branchTaken=1 with hit=0 in IDLE -> no REFILL entered.
- rst=1 after the second ack of a refill -> next cycle busy=0, memReq=0, beat=0. A new miss then restarts at memAddr=base+0. With FETCH_MISS_COUNT_EN defined, missCount=1 after the first miss and returns to 0 on rst.
